// File: rtl/p2s_tx_pkg.sv
// Shared types and constants for the p2s_tx_sched parallel-to-serial scheduler.
package p2s_tx_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NSHIFT = 8;
    localparam int unsigned CNT_W  = $clog2(NSHIFT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: combinational search from the pointer upward, with a
// registered pointer that advances past the winner only when a grant is taken.
module rr_arb
    import p2s_tx_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             gnt_en,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   idx,
    output logic             valid
);

    localparam int unsigned CW = IDW + 1;
    localparam logic [CW-1:0] NREQ_C = CW'(N_REQ);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [CW-1:0]  cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= NREQ_C) begin
                cand = cand - NREQ_C;
            end
            if (!valid && req[cand[IDW-1:0]]) begin
                valid                = 1'b1;
                idx                  = cand[IDW-1:0];
                gnt[cand[IDW-1:0]]   = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_en && valid) begin
            ptr_d = (idx == IDW'(N_REQ - 1)) ? '0 : idx + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/p2s_tx_sched.sv
// Shares one 8-bit P2S shifter among N_REQ requesters: grant, one load, 8 shifts, done.
// Optional P2S_TX_SCHED_GAP_EN inserts a one-cycle GAP state after each frame.
module p2s_tx_sched
    import p2s_tx_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic                    hold,
    output logic [N_REQ-1:0]        gnt,
    output logic                    load,
    output logic                    shift,
    output logic [BYTE_W-1:0]       p_data,
    output logic                    busy,
    output logic                    done,
    output logic [IDW-1:0]          cur_id
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               load_q, load_d;
    logic               shift_q, shift_d;
    logic [BYTE_W-1:0]  p_data_q, p_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IDW-1:0]     cur_id_q, cur_id_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [IDW-1:0]     arb_idx;
    logic               arb_valid;
    logic [BYTE_W-1:0]  win_byte;
    logic [CNT_W-1:0]   shifts_now;
    logic               last_shift;

    rr_arb #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .gnt_en (state_q == IDLE),
        .gnt    (arb_gnt),
        .idx    (arb_idx),
        .valid  (arb_valid)
    );

    always_comb begin
        win_byte = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_idx == IDW'(i)) begin
                win_byte = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // The shift issued in the current cycle counts toward the total at this edge.
    assign shifts_now = cnt_q + CNT_W'(shift_q);
    assign last_shift = (state_q == SHIFT) && (shifts_now == CNT_W'(NSHIFT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gnt_q    <= '0;
            load_q   <= 1'b0;
            shift_q  <= 1'b0;
            p_data_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cur_id_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            load_q   <= load_d;
            shift_q  <= shift_d;
            p_data_q <= p_data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cur_id_q <= cur_id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (arb_valid) state_d = LOAD;
            LOAD:  state_d = SHIFT;
            SHIFT: begin
                if (last_shift) begin
`ifdef P2S_TX_SCHED_GAP_EN
                    state_d = GAP;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d    = '0;
        load_d   = 1'b0;
        shift_d  = 1'b0;
        done_d   = 1'b0;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        p_data_d = p_data_q;
        cur_id_d = cur_id_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d    = arb_gnt;
                    load_d   = 1'b1;
                    busy_d   = 1'b1;
                    p_data_d = win_byte;
                    cur_id_d = arb_idx;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                shift_d = !hold;
                busy_d  = 1'b1;
            end
            SHIFT: begin
                cnt_d = shifts_now;
                if (last_shift) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    shift_d = !hold;
                end
            end
            default: busy_d = 1'b0;
        endcase
    end

    assign gnt    = gnt_q;
    assign load   = load_q;
    assign shift  = shift_q;
    assign p_data = p_data_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign cur_id = cur_id_q;

endmodule

// File: tb/tb_p2s_tx_sched.sv
// Directed self-checking bench for p2s_tx_sched (N_REQ=2) with an LSB-first shifter model.
module tb_p2s_tx_sched;

`ifdef P2S_TX_SCHED_GAP_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [15:0] req_data = '0;
    logic        hold = 1'b0;
    logic [1:0]  gnt;
    logic        load;
    logic        shift;
    logic [7:0]  p_data;
    logic        busy;
    logic        done;
    logic [0:0]  cur_id;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    p2s_tx_sched #(.N_REQ(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .hold     (hold),
        .gnt      (gnt),
        .load     (load),
        .shift    (shift),
        .p_data   (p_data),
        .busy     (busy),
        .done     (done),
        .cur_id   (cur_id)
    );

    // Attached shifter: captures on load, emits bit0 first on each shift.
    logic [7:0] sr = '0;
    logic       sout = 1'b0;
    always_ff @(posedge clk) begin
        if (load) begin
            sr <= p_data;
        end else if (shift) begin
            sout <= sr[0];
            sr   <= sr >> 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; hold = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b11; hold = 1'b0; req_data = 16'h3CA5;
        tick(); tick();
        checks++;
        if ({gnt, load, shift, busy, done} !== 6'b0)
            begin failures++; $display("FAIL reset_ctrl: got %b expected 000000", {gnt, load, shift, busy, done}); end
        checks++;
        if ({p_data, cur_id} !== 9'h0)
            begin failures++; $display("FAIL reset_data: got %h expected 000", {p_data, cur_id}); end
        rst = 1'b0; req = '0;
    endtask

    task automatic test_single();
        int shift_cnt = 0, done_at = -1, done_cnt = 0, extra_load = 0;
        logic [7:0] got = '0;
        do_reset();
        req_data = 16'h3CA5; req = 2'b01;
        tick();
        checks++;
        if ({gnt, load, shift, busy} !== 5'b01101)
            begin failures++; $display("FAIL single_grant: got %b expected 01101", {gnt, load, shift, busy}); end
        checks++;
        if (p_data !== 8'hA5 || cur_id !== 1'b0)
            begin failures++; $display("FAIL single_pdata: got %h/%0d expected a5/0", p_data, cur_id); end
        req = '0;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if ({gnt, load, shift} !== 4'b0001)
                    begin failures++; $display("FAIL single_load_end: got %b expected 0001", {gnt, load, shift}); end
            end
            if (shift) shift_cnt++;
            if (load) extra_load++;
            if (c >= 2 && c <= 9) got[c-2] = sout;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
        end
        checks++;
        if (shift_cnt !== 8)
            begin failures++; $display("FAIL single_shifts: got %0d expected 8", shift_cnt); end
        checks++;
        if (done_at !== 9 || done_cnt !== 1)
            begin failures++; $display("FAIL single_done: got at %0d x%0d expected at 9 x1", done_at, done_cnt); end
        checks++;
        if (got !== 8'hA5)
            begin failures++; $display("FAIL single_serial: got %h expected a5", got); end
        checks++;
        if (extra_load !== 0 || busy !== 1'b0 || p_data !== 8'hA5)
            begin failures++; $display("FAIL single_after: got loads=%0d busy=%b p=%h expected 0/0/a5", extra_load, busy, p_data); end
    endtask

    task automatic test_contention();
        int ids[4];
        int at[4];
        logic [7:0] pd[4];
        logic [1:0] gv[4];
        int n = 0;
        do_reset();
        req_data = 16'h3CA5; req = 2'b11;
        for (int c = 0; c < 60 && n < 4; c++) begin
            tick();
            if (gnt !== 2'b00) begin
                ids[n] = int'(cur_id); at[n] = c; pd[n] = p_data; gv[n] = gnt;
                n++;
            end
        end
        req = '0;
        checks++;
        if (n !== 4)
            begin failures++; $display("FAIL contend_count: got %0d grants expected 4", n); end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (ids[k] !== k % 2 || gv[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10) ||
                pd[k] !== ((k % 2 == 0) ? 8'hA5 : 8'h3C))
                begin failures++; $display("FAIL contend_grant%0d: got id=%0d gnt=%b p=%h expected id=%0d", k, ids[k], gv[k], pd[k], k % 2); end
            if (k > 0) begin
                checks++;
                if (at[k] - at[k-1] !== FRAME)
                    begin failures++; $display("FAIL contend_spacing%0d: got %0d expected %0d", k, at[k] - at[k-1], FRAME); end
            end
        end
    endtask

    task automatic test_hold();
        int shift_cnt = 0, held_shifts = 0, done_at = -1, done_cnt = 0;
        logic resume = 1'b0;
        do_reset();
        req_data = 16'h3CA5; req = 2'b01;
        tick();
        req = '0;
        for (int c = 1; c <= 16; c++) begin
            hold = (c >= 3 && c <= 6);
            tick();
            if (shift) shift_cnt++;
            if (shift && c >= 3 && c <= 6) held_shifts++;
            if (c == 7) resume = shift;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
        end
        hold = 1'b0;
        checks++;
        if (held_shifts !== 0 || resume !== 1'b1)
            begin failures++; $display("FAIL hold_stall: got held=%0d resume=%b expected 0/1", held_shifts, resume); end
        checks++;
        if (shift_cnt !== 8)
            begin failures++; $display("FAIL hold_shifts: got %0d expected 8", shift_cnt); end
        checks++;
        if (done_at !== 13 || done_cnt !== 1)
            begin failures++; $display("FAIL hold_done: got at %0d x%0d expected at 13 x1", done_at, done_cnt); end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        do_reset();
        req_data = 16'h3CA5; req = 2'b01;
        tick();
        req = '0;
        tick(); tick(); tick();
        checks++;
        if (shift !== 1'b1 || busy !== 1'b1)
            begin failures++; $display("FAIL rstmid_pre: got shift=%b busy=%b expected 1/1", shift, busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({gnt, load, shift, busy, done, p_data, cur_id} !== 15'h0)
            begin failures++; $display("FAIL rstmid_clear: got %h expected 0000", {gnt, load, shift, busy, done, p_data, cur_id}); end
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done || busy || shift) stray++;
        end
        checks++;
        if (stray !== 0)
            begin failures++; $display("FAIL rstmid_nodone: got %0d active cycles expected 0", stray); end
        req = 2'b11;
        tick();
        req = '0;
        checks++;
        if (load !== 1'b1 || gnt !== 2'b01 || cur_id !== 1'b0)
            begin failures++; $display("FAIL rstmid_restart: got load=%b gnt=%b id=%0d expected 1/01/0", load, gnt, cur_id); end
    endtask

    task automatic test_fairness();
        logic [1:0] seq[3];
        int n = 0;
        do_reset();
        req_data = 16'h3CA5; req = 2'b10;
        for (int c = 0; c < 4 * FRAME && n < 3; c++) begin
            tick();
            if (gnt !== 2'b00) begin
                seq[n] = gnt;
                n++;
                req = 2'b11;
            end
        end
        req = '0;
        checks++;
        if (n !== 3)
            begin failures++; $display("FAIL fair_count: got %0d grants expected 3", n); end
        else begin
            checks++;
            if (seq[0] !== 2'b10 || seq[1] !== 2'b01 || seq[2] !== 2'b10)
                begin failures++; $display("FAIL fair_order: got %b %b %b expected 10 01 10", seq[0], seq[1], seq[2]); end
        end
    endtask

    task automatic test_protocol();
        int bad_ls = 0, bad_oh = 0, bad_gl = 0, bad_cnt = 0, frames = 0, sc = 0;
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            req = 2'($urandom_range(0, 3));
            hold = ($urandom_range(0, 3) == 0);
            req_data = 16'($urandom);
            tick();
            if (load && shift) bad_ls++;
            if (!$onehot0(gnt)) bad_oh++;
            if ((gnt !== 2'b00) !== load) bad_gl++;
            if (load) sc = 0;
            if (shift) sc++;
            if (done) begin
                frames++;
                if (sc !== 8) bad_cnt++;
            end
        end
        req = '0; hold = 1'b0;
        checks++;
        if (bad_ls !== 0)
            begin failures++; $display("FAIL proto_load_shift: got %0d overlaps expected 0", bad_ls); end
        checks++;
        if (bad_oh !== 0 || bad_gl !== 0)
            begin failures++; $display("FAIL proto_gnt: got onehot=%0d coincide=%0d violations expected 0", bad_oh, bad_gl); end
        checks++;
        if (bad_cnt !== 0 || frames < 20)
            begin failures++; $display("FAIL proto_frames: got bad=%0d frames=%0d expected 0 and >=20", bad_cnt, frames); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_hold();
        test_reset_mid();
        test_fairness();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
